// File: rtl/srdl_counter_field.sv
// SystemRDL counter field: software/hardware write path, combined incr/decr
// datapath with optional saturation, thresholds, sticky status and interrupt.
module srdl_counter_field #(
  parameter int unsigned      WIDTH      = 8,
  parameter logic [WIDTH-1:0] RESET      = '0,
  parameter int unsigned      INCR_WIDTH = 1,
  parameter int unsigned      DECR_WIDTH = 1,
  parameter bit               SAT_EN     = 1'b0,
  parameter logic [WIDTH-1:0] INCR_SAT   = '1,
  parameter logic [WIDTH-1:0] DECR_SAT   = '0,
  parameter logic [WIDTH-1:0] INCR_THR   = '1,
  parameter logic [WIDTH-1:0] DECR_THR   = '0,
  parameter string            SW_WRITE   = "plain",
  parameter bit               RCLR       = 1'b0
) (
  input  logic                  clk,
  input  logic                  rst_l,
  input  logic                  sw_rd,
  input  logic                  sw_wr,
  input  logic [WIDTH-1:0]      sw_wdata,
  output logic [WIDTH-1:0]      sw_rdata,
  input  logic                  hw_we,
  input  logic [WIDTH-1:0]      hw_wdata,
  input  logic                  hwclr,
  input  logic                  incr,
  input  logic [INCR_WIDTH-1:0] incrvalue,
  input  logic                  decr,
  input  logic [DECR_WIDTH-1:0] decrvalue,
  input  logic                  sts_clr,
  output logic [WIDTH-1:0]      q,
  output logic                  overflow,
  output logic                  underflow,
  output logic                  incr_thr,
  output logic                  decr_thr,
  output logic                  ovf_sticky,
  output logic                  unf_sticky,
  output logic                  thr_sticky,
  output logic                  swmod,
  output logic                  intr
);

  // Two extra bits: one for carry out of WIDTH, one as sign for borrow.
  localparam int unsigned SW = WIDTH + 2;

  localparam bit WR_PLAIN = (SW_WRITE == "plain");
  localparam bit WR_SET   = (SW_WRITE == "woset");
  localparam bit WR_CLR   = (SW_WRITE == "woclr");
  localparam bit WR_ANY   = WR_PLAIN || WR_SET || WR_CLR;

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovs_q, ovs_d;
  logic             uns_q, uns_d;
  logic             ths_q, ths_d;
  logic             thr_prev_q;
  logic             swmod_q, swmod_d;

  logic [WIDTH-1:0] n_sw;
  logic [WIDTH-1:0] n_hw;
  logic [SW-1:0]    add_amt;
  logic [SW-1:0]    sub_amt;
  logic [SW-1:0]    sum;
  logic             thr_rise;

  // Next-value pipeline: read-clear, sw write, hw write, counter, hwclr.
  always_comb begin
    n_sw    = q_q;
    n_hw    = q_q;
    add_amt = '0;
    sub_amt = '0;
    sum     = '0;
    q_d     = q_q;
    ovf_d   = 1'b0;
    unf_d   = 1'b0;
    swmod_d = 1'b0;

    if (RCLR && sw_rd) n_sw = '0;
    if (sw_wr) begin
      if (WR_PLAIN)    n_sw = sw_wdata;
      else if (WR_SET) n_sw = n_sw | sw_wdata;
      else if (WR_CLR) n_sw = n_sw & ~sw_wdata;
    end
    swmod_d = sw_wr && WR_ANY && (n_sw != q_q);

    n_hw = hw_we ? hw_wdata : n_sw;

    if (incr) add_amt = SW'(incrvalue);
    if (decr) sub_amt = SW'(decrvalue);
    sum   = SW'(n_hw) + add_amt - sub_amt;
    unf_d = sum[SW-1];
    ovf_d = !sum[SW-1] && sum[WIDTH];

    if (SAT_EN) begin
      if ($signed(sum) > $signed(SW'(INCR_SAT)))      q_d = INCR_SAT;
      else if ($signed(sum) < $signed(SW'(DECR_SAT))) q_d = DECR_SAT;
      else                                            q_d = sum[WIDTH-1:0];
    end else begin
      q_d = sum[WIDTH-1:0];
    end

    if (hwclr) begin
      q_d   = '0;
      ovf_d = 1'b0;
      unf_d = 1'b0;
    end
  end

  assign incr_thr = (q_q >= INCR_THR);
  assign decr_thr = (q_q <= DECR_THR);
  assign thr_rise = incr_thr && !thr_prev_q;

  // Stickies: a set in the same cycle beats sts_clr.
  assign ovs_d = ovf_d    || (ovs_q && !sts_clr);
  assign uns_d = unf_d    || (uns_q && !sts_clr);
  assign ths_d = thr_rise || (ths_q && !sts_clr);

  always_ff @(posedge clk or negedge rst_l) begin
    if (!rst_l) begin
      q_q        <= RESET;
      ovf_q      <= 1'b0;
      unf_q      <= 1'b0;
      ovs_q      <= 1'b0;
      uns_q      <= 1'b0;
      ths_q      <= 1'b0;
      thr_prev_q <= 1'b0;
      swmod_q    <= 1'b0;
    end else begin
      q_q        <= q_d;
      ovf_q      <= ovf_d;
      unf_q      <= unf_d;
      ovs_q      <= ovs_d;
      uns_q      <= uns_d;
      ths_q      <= ths_d;
      thr_prev_q <= incr_thr;
      swmod_q    <= swmod_d;
    end
  end

  assign q          = q_q;
  assign sw_rdata   = q_q;
  assign overflow   = ovf_q;
  assign underflow  = unf_q;
  assign ovf_sticky = ovs_q;
  assign unf_sticky = uns_q;
  assign thr_sticky = ths_q;
  assign swmod      = swmod_q;
  assign intr       = ovs_q || uns_q || ths_q;

endmodule

// File: tb/tb_srdl_counter_field.sv
// Directed table-driven bench: one wrapping/woclr instance and one
// saturating/plain/read-clear instance sharing clock and reset.
module tb_srdl_counter_field;

  typedef struct packed {
    logic       rd;
    logic       wr;
    logic [7:0] wdata;
    logic       hwe;
    logic [7:0] hwdata;
    logic       clr;
    logic       inc;
    logic [3:0] incv;
    logic       dec;
    logic [3:0] decv;
    logic       sclr;
  } in_t;

  // flg = {overflow, underflow, swmod, ovf_st, unf_st, thr_st, incr_thr, decr_thr, intr}
  typedef struct packed {
    in_t        in;
    logic [7:0] q;
    logic [8:0] flg;
  } vec_t;

  logic clk;
  logic rst_l;
  in_t  ia;
  in_t  ib;
  int   n_tests;
  int   n_fail;

  logic [7:0] qa, ra, qb, rb;
  logic ovf_a, unf_a, ithr_a, dthr_a, ovs_a, uns_a, ths_a, swm_a, intr_a;
  logic ovf_b, unf_b, ithr_b, dthr_b, ovs_b, uns_b, ths_b, swm_b, intr_b;

  srdl_counter_field #(
    .WIDTH(8), .RESET(8'h5A), .INCR_WIDTH(4), .DECR_WIDTH(4), .SAT_EN(1'b0),
    .INCR_SAT(8'hFF), .DECR_SAT(8'h00), .INCR_THR(8'h40), .DECR_THR(8'h08),
    .SW_WRITE("woclr"), .RCLR(1'b0)
  ) u_a (
    .clk(clk), .rst_l(rst_l), .sw_rd(ia.rd), .sw_wr(ia.wr), .sw_wdata(ia.wdata),
    .sw_rdata(ra), .hw_we(ia.hwe), .hw_wdata(ia.hwdata), .hwclr(ia.clr),
    .incr(ia.inc), .incrvalue(ia.incv), .decr(ia.dec), .decrvalue(ia.decv),
    .sts_clr(ia.sclr), .q(qa), .overflow(ovf_a), .underflow(unf_a),
    .incr_thr(ithr_a), .decr_thr(dthr_a), .ovf_sticky(ovs_a), .unf_sticky(uns_a),
    .thr_sticky(ths_a), .swmod(swm_a), .intr(intr_a)
  );

  srdl_counter_field #(
    .WIDTH(8), .RESET(8'h20), .INCR_WIDTH(4), .DECR_WIDTH(4), .SAT_EN(1'b1),
    .INCR_SAT(8'hF0), .DECR_SAT(8'h10), .INCR_THR(8'hFF), .DECR_THR(8'h10),
    .SW_WRITE("plain"), .RCLR(1'b1)
  ) u_b (
    .clk(clk), .rst_l(rst_l), .sw_rd(ib.rd), .sw_wr(ib.wr), .sw_wdata(ib.wdata),
    .sw_rdata(rb), .hw_we(ib.hwe), .hw_wdata(ib.hwdata), .hwclr(ib.clr),
    .incr(ib.inc), .incrvalue(ib.incv), .decr(ib.dec), .decrvalue(ib.decv),
    .sts_clr(ib.sclr), .q(qb), .overflow(ovf_b), .underflow(unf_b),
    .incr_thr(ithr_b), .decr_thr(dthr_b), .ovf_sticky(ovs_b), .unf_sticky(uns_b),
    .thr_sticky(ths_b), .swmod(swm_b), .intr(intr_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [8:0] flags_a();
    return {ovf_a, unf_a, swm_a, ovs_a, uns_a, ths_a, ithr_a, dthr_a, intr_a};
  endfunction

  function automatic logic [8:0] flags_b();
    return {ovf_b, unf_b, swm_b, ovs_b, uns_b, ths_b, ithr_b, dthr_b, intr_b};
  endfunction

  task automatic check(input string name, input int idx, input logic [7:0] q,
                       input logic [7:0] rdata, input logic [8:0] flg,
                       input logic [7:0] e_q, input logic [8:0] e_flg);
    n_tests += 3;
    if (q !== e_q) begin
      n_fail++;
      $display("FAIL %s[%0d] q: got %h expected %h", name, idx, q, e_q);
    end
    if (rdata !== e_q) begin
      n_fail++;
      $display("FAIL %s[%0d] sw_rdata: got %h expected %h", name, idx, rdata, e_q);
    end
    if (flg !== e_flg) begin
      n_fail++;
      $display("FAIL %s[%0d] flags: got %b expected %b", name, idx, flg, e_flg);
    end
  endtask

  vec_t va[15];
  vec_t vb[13];

  initial begin
    n_tests = 0;
    n_fail  = 0;
    ia      = '0;
    ib      = '0;
    rst_l   = 1'b0;

    //           rd wr wdata  hwe hwdata clr inc incv dec decv sclr    q       flags
    va[0]  = '{'{0, 0, 8'h00, 1, 8'hFE, 0, 0, 4'h0, 0, 4'h0, 0}, 8'hFE, 9'b000001101};
    va[1]  = '{'{0, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 1}, 8'hFE, 9'b000000100};
    va[2]  = '{'{0, 0, 8'h00, 0, 8'h00, 0, 1, 4'h3, 0, 4'h0, 0}, 8'h01, 9'b100100011};
    va[3]  = '{'{0, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 0}, 8'h01, 9'b000100011};
    va[4]  = '{'{0, 0, 8'h00, 1, 8'h02, 0, 0, 4'h0, 0, 4'h0, 1}, 8'h02, 9'b000000010};
    va[5]  = '{'{0, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0, 1, 4'h3, 0}, 8'hFF, 9'b010010101};
    va[6]  = '{'{0, 0, 8'h00, 1, 8'h00, 0, 0, 4'h0, 1, 4'h1, 1}, 8'hFF, 9'b010011101};
    va[7]  = '{'{0, 1, 8'h0F, 0, 8'h00, 0, 1, 4'h1, 0, 4'h0, 1}, 8'hF1, 9'b001000100};
    va[8]  = '{'{0, 1, 8'h00, 0, 8'h00, 0, 1, 4'h2, 1, 4'h2, 0}, 8'hF1, 9'b000000100};
    va[9]  = '{'{0, 0, 8'h00, 1, 8'h80, 1, 1, 4'hF, 0, 4'h0, 0}, 8'h00, 9'b000000010};
    va[10] = '{'{0, 0, 8'h00, 1, 8'h3F, 0, 0, 4'h0, 0, 4'h0, 0}, 8'h3F, 9'b000000000};
    va[11] = '{'{0, 0, 8'h00, 0, 8'h00, 0, 1, 4'h1, 0, 4'h0, 0}, 8'h40, 9'b000000100};
    va[12] = '{'{0, 0, 8'h00, 0, 8'h00, 0, 1, 4'h1, 0, 4'h0, 0}, 8'h41, 9'b000001101};
    va[13] = '{'{0, 0, 8'h00, 0, 8'h00, 0, 1, 4'h1, 0, 4'h0, 0}, 8'h42, 9'b000001101};
    va[14] = '{'{0, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 1}, 8'h42, 9'b000000100};

    vb[0]  = '{'{0, 0, 8'h00, 1, 8'hEE, 0, 0, 4'h0, 0, 4'h0, 0}, 8'hEE, 9'b000000000};
    vb[1]  = '{'{0, 0, 8'h00, 0, 8'h00, 0, 1, 4'h5, 0, 4'h0, 0}, 8'hF0, 9'b000000000};
    vb[2]  = '{'{0, 0, 8'h00, 0, 8'h00, 0, 1, 4'hF, 0, 4'h0, 0}, 8'hF0, 9'b000000000};
    vb[3]  = '{'{0, 0, 8'h00, 1, 8'hFE, 0, 1, 4'h3, 0, 4'h0, 0}, 8'hF0, 9'b100100001};
    vb[4]  = '{'{0, 0, 8'h00, 1, 8'h11, 0, 0, 4'h0, 0, 4'h0, 0}, 8'h11, 9'b000100001};
    vb[5]  = '{'{0, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0, 1, 4'h1, 0}, 8'h10, 9'b000100011};
    vb[6]  = '{'{0, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0, 1, 4'h1, 1}, 8'h10, 9'b000000010};
    vb[7]  = '{'{0, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0, 1, 4'h1, 0}, 8'h10, 9'b000000010};
    vb[8]  = '{'{0, 1, 8'h33, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 0}, 8'h33, 9'b001000000};
    vb[9]  = '{'{1, 0, 8'h00, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 0}, 8'h10, 9'b000000010};
    vb[10] = '{'{0, 1, 8'h10, 0, 8'h00, 0, 0, 4'h0, 0, 4'h0, 0}, 8'h10, 9'b000000010};
    vb[11] = '{'{0, 0, 8'h00, 1, 8'h05, 0, 0, 4'h0, 1, 4'hF, 0}, 8'h10, 9'b010010011};
    vb[12] = '{'{0, 0, 8'h00, 0, 8'h00, 1, 0, 4'h0, 1, 4'h1, 0}, 8'h00, 9'b000010011};

    #12;
    check("rst_a", 0, qa, ra, flags_a(), 8'h5A, 9'b000000100);
    check("rst_b", 0, qb, rb, flags_b(), 8'h20, 9'b000000000);
    rst_l = 1'b1;

    foreach (va[i]) begin
      ia = va[i].in;
      @(posedge clk);
      #1;
      check("vec_a", i, qa, ra, flags_a(), va[i].q, va[i].flg);
    end
    ia = '0;

    foreach (vb[i]) begin
      ib = vb[i].in;
      @(posedge clk);
      #1;
      check("vec_b", i, qb, rb, flags_b(), vb[i].q, vb[i].flg);
    end
    ib = '0;

    // Wrap to set ovf_sticky, keep counting, then drop reset between edges.
    ia = '0;
    ia.hwe = 1'b1; ia.hwdata = 8'hFF; ia.inc = 1'b1; ia.incv = 4'h1;
    @(posedge clk);
    #1;
    ia.hwe = 1'b0;
    @(posedge clk);
    #1;
    check("pre_rst", 0, qa, ra, flags_a(), 8'h01, 9'b000100011);
    #3;
    rst_l = 1'b0;
    #1;
    check("mid_rst", 0, qa, ra, flags_a(), 8'h5A, 9'b000000100);
    @(posedge clk);
    #1;
    check("hold_rst", 0, qa, ra, flags_a(), 8'h5A, 9'b000000100);
    #2;
    rst_l = 1'b1;
    @(posedge clk);
    #1;
    check("post_rst", 0, qa, ra, flags_a(), 8'h5B, 9'b000001101);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
